// File: rtl/bus_access_ctrl.sv
// bus_access_ctrl: sequences the 8-bit bidirectional data-bus buffer from
// the CPU strobes. It issues direction codes, internal read requests and
// write pulses, and never drives both buses in the same cycle.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   CS_n, RD_n, WR_n external strobes, active low
//   A[1:0]           register address from the external bus
//   Internal_RD_WR   buffer direction, internal side
//   RD_WR            buffer direction, external side
//   sel[1:0]         address frozen at access start
//   int_rd_req       internal read request (held through R_FETCH)
//   int_wr           one-cycle internal register load pulse
//   busy             high outside IDLE
//   err              sticky RD_n/WR_n conflict flag
//
// Parameter WAIT_CYCLES (1..15): internal read latency in clk cycles.
// Optional macro STROBE_SYNC_EN: adds a 2-flop synchronizer on each strobe
// (and a matching 2-stage delay on A), which adds 2 cycles to every latency.
module bus_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    output logic       Internal_RD_WR,
    output logic       RD_WR,
    output logic [1:0] sel,
    output logic       int_rd_req,
    output logic       int_wr,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLATCH,
        S_WPUSH,
        S_WWAIT,
        S_RFETCH,
        S_RDRIVE
    } state_t;

    logic       cs_s;
    logic       rd_s;
    logic       wr_s;
    logic [1:0] a_s;

`ifdef STROBE_SYNC_EN
    // Strobe order in the vectors: {CS_n, RD_n, WR_n}.
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [1:0] adly1_q, adly1_d;
    logic [1:0] adly2_q, adly2_d;

    always_comb begin
        sync1_d = {CS_n, RD_n, WR_n};
        sync2_d = sync1_q;
        adly1_d = A;
        adly2_d = adly1_q;
    end

    // Synchronizers reset to the inactive (high) level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            adly1_q <= 2'b00;
            adly2_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            adly1_q <= adly1_d;
            adly2_q <= adly2_d;
        end
    end

    assign cs_s = sync2_q[2];
    assign rd_s = sync2_q[1];
    assign wr_s = sync2_q[0];
    assign a_s  = adly2_q;
`else
    assign cs_s = CS_n;
    assign rd_s = RD_n;
    assign wr_s = WR_n;
    assign a_s  = A;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       err_q, err_d;
    logic       irw_q, irw_d;
    logic       rw_q, rw_d;
    logic       rq_q, rq_d;
    logic       iw_q, iw_d;
    logic       busy_q, busy_d;

    logic rd_start;
    logic wr_start;
    logic conflict;

    always_comb begin
        rd_start = !cs_s && !rd_s && wr_s;
        wr_start = !cs_s && !wr_s && rd_s;
        conflict = !cs_s && !rd_s && !wr_s;

        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_d   = err_q | conflict;

        unique case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    state_d = S_WLATCH;
                    sel_d   = a_s;
                end else if (rd_start) begin
                    state_d = S_RFETCH;
                    sel_d   = a_s;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            // Write strobe is not checked here: a latched write always
            // reaches the internal register.
            S_WLATCH: state_d = S_WPUSH;
            S_WPUSH:  state_d = S_WWAIT;
            S_WWAIT: begin
                if (wr_s || cs_s) state_d = S_IDLE;
            end
            S_RFETCH: begin
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                // Release wins over completion so the external bus is
                // never driven for an abandoned read.
                if (rd_s || cs_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RDRIVE;
                end
            end
            S_RDRIVE: begin
                if (rd_s || cs_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs decode the next state so they leave straight from flops.
        irw_d  = 1'b0;
        rw_d   = 1'b1;
        rq_d   = 1'b0;
        iw_d   = 1'b0;
        busy_d = (state_d != S_IDLE);
        unique case (state_d)
            S_WLATCH: begin
                irw_d = 1'b1;
                rw_d  = 1'b1;
            end
            S_WPUSH: begin
                irw_d = 1'b0;
                rw_d  = 1'b0;
                iw_d  = 1'b1;
            end
            S_RFETCH: rq_d = 1'b1;
            S_RDRIVE: begin
                irw_d = 1'b1;
                rw_d  = 1'b0;
            end
            default: begin
                irw_d = 1'b0;
                rw_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            err_q   <= 1'b0;
            irw_q   <= 1'b0;
            rw_q    <= 1'b1;
            rq_q    <= 1'b0;
            iw_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            irw_q   <= irw_d;
            rw_q    <= rw_d;
            rq_q    <= rq_d;
            iw_q    <= iw_d;
            busy_q  <= busy_d;
        end
    end

    assign Internal_RD_WR = irw_q;
    assign RD_WR          = rw_q;
    assign sel            = sel_q;
    assign int_rd_req     = rq_q;
    assign int_wr         = iw_q;
    assign busy           = busy_q;
    assign err            = err_q;

endmodule

// File: tb/tb_bus_access_ctrl.sv
// tb_bus_access_ctrl: directed bench for bus_access_ctrl with three
// instances (WAIT_CYCLES = 1, 3, 5) sharing the same strobes.
module tb_bus_access_ctrl;

`ifdef STROBE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    // Direction codes {Internal_RD_WR, RD_WR}
    localparam logic [1:0] C_IDLE = 2'b01;
    localparam logic [1:0] C_WL   = 2'b11;
    localparam logic [1:0] C_WP   = 2'b00;
    localparam logic [1:0] C_RD   = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       CS_n = 1'b1;
    logic       RD_n = 1'b1;
    logic       WR_n = 1'b1;
    logic [1:0] A = 2'd0;

    logic       irw [3];
    logic       rw  [3];
    logic [1:0] sl  [3];
    logic       rq  [3];
    logic       iw  [3];
    logic       bz  [3];
    logic       er  [3];

    // Packed view per instance: {code[1:0], sel[1:0], rq, iw, busy, err}
    logic [7:0] o [3];

    int vecs = 0;
    int errs = 0;
    logic [1:0] ps = 2'd0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            o[k] = {irw[k], rw[k], sl[k], rq[k], iw[k], bz[k], er[k]};
        end
    end

    bus_access_ctrl #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A),
        .Internal_RD_WR(irw[0]), .RD_WR(rw[0]), .sel(sl[0]),
        .int_rd_req(rq[0]), .int_wr(iw[0]), .busy(bz[0]), .err(er[0])
    );

    bus_access_ctrl #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A),
        .Internal_RD_WR(irw[1]), .RD_WR(rw[1]), .sel(sl[1]),
        .int_rd_req(rq[1]), .int_wr(iw[1]), .busy(bz[1]), .err(er[1])
    );

    bus_access_ctrl #(.WAIT_CYCLES(5)) u5 (
        .clk(clk), .rst(rst), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A),
        .Internal_RD_WR(irw[2]), .RD_WR(rw[2]), .sel(sl[2]),
        .int_rd_req(rq[2]), .int_wr(iw[2]), .busy(bz[2]), .err(er[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b0;
        repeat (2) step();
        e = {C_IDLE, 2'd0, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (o[k] !== e) begin
                errs++;
                $display("FAIL reset inst%0d: got %b want %b", k, o[k], e);
            end
        end
        rst = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (o[k] !== e) begin
                errs++;
                $display("FAIL post_reset inst%0d: got %b want %b", k, o[k], e);
            end
        end
        ps = 2'd0;
    endtask

    task automatic test_write();
        logic [7:0] e;
        A = 2'd2;
        CS_n = 1'b0;
        WR_n = 1'b0;
        repeat (SD) step();
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) A = 2'd3;
            if (i == 1)      e = {C_WL, 2'd2, 4'b0010};
            else if (i == 2) e = {C_WP, 2'd2, 4'b0110};
            else             e = {C_IDLE, 2'd2, 4'b0010};
            vecs++;
            if (o[0] !== e) begin
                errs++;
                $display("FAIL write step%0d: got %b want %b", i, o[0], e);
            end
        end
        WR_n = 1'b1;
        repeat (SD) step();
        step();
        e = {C_IDLE, 2'd2, 4'b0000};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL write_release: got %b want %b", o[0], e);
        end
        CS_n = 1'b1;
        A = 2'd0;
        ps = 2'd2;
    endtask

    task automatic test_read();
        logic [7:0] e;
        int w;
        A = 2'd1;
        CS_n = 1'b0;
        RD_n = 1'b0;
        repeat (SD) step();
        for (int i = 1; i <= 7; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                w = (k == 0) ? 1 : (k == 1) ? 3 : 5;
                if (i <= w + 1) e = {C_IDLE, 2'd1, 4'b1010};
                else            e = {C_RD, 2'd1, 4'b0010};
                vecs++;
                if (o[k] !== e) begin
                    errs++;
                    $display("FAIL read w%0d step%0d: got %b want %b", w, i, o[k], e);
                end
            end
        end
        RD_n = 1'b1;
        repeat (SD) step();
        step();
        e = {C_IDLE, 2'd1, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (o[k] !== e) begin
                errs++;
                $display("FAIL read_release inst%0d: got %b want %b", k, o[k], e);
            end
        end
        CS_n = 1'b1;
        ps = 2'd1;
    endtask

    task automatic test_read_abort();
        logic [7:0] e;
        A = 2'd2;
        CS_n = 1'b0;
        RD_n = 1'b0;
        repeat (SD) step();
        e = {C_IDLE, 2'd2, 4'b1010};
        for (int i = 1; i <= 2; i++) begin
            step();
            vecs++;
            if (o[2] !== e) begin
                errs++;
                $display("FAIL abort_fetch step%0d: got %b want %b", i, o[2], e);
            end
        end
        RD_n = 1'b1;
        repeat (SD) step();
        e = {C_IDLE, 2'd2, 4'b0000};
        for (int i = 1; i <= 4; i++) begin
            step();
            vecs++;
            if (o[2] !== e) begin
                errs++;
                $display("FAIL abort_idle step%0d: got %b want %b", i, o[2], e);
            end
        end
        CS_n = 1'b1;
        ps = 2'd2;
    endtask

    task automatic test_short_write();
        logic [7:0] e;
        int j;
        int pulses;
        pulses = 0;
        A = 2'd3;
        CS_n = 1'b0;
        WR_n = 1'b0;
        for (int i = 0; i < SD + 6; i++) begin
            step();
            if (i == 0) begin
                WR_n = 1'b1;
                CS_n = 1'b1;
            end
            j = i - SD;
            if (j < 0)       e = {C_IDLE, ps, 4'b0000};
            else if (j == 0) e = {C_WL, 2'd3, 4'b0010};
            else if (j == 1) e = {C_WP, 2'd3, 4'b0110};
            else if (j == 2) e = {C_IDLE, 2'd3, 4'b0010};
            else             e = {C_IDLE, 2'd3, 4'b0000};
            if (iw[0] === 1'b1) pulses++;
            vecs++;
            if (o[0] !== e) begin
                errs++;
                $display("FAIL short_write step%0d: got %b want %b", i, o[0], e);
            end
        end
        vecs++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL short_write_pulses: got %0d want 1", pulses);
        end
        ps = 2'd3;
    endtask

    task automatic test_conflict_reset();
        logic [7:0] e;
        A = 2'd1;
        CS_n = 1'b0;
        RD_n = 1'b0;
        WR_n = 1'b0;
        repeat (SD + 1) step();
        e = {C_IDLE, ps, 4'b0001};
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (o[k] !== e) begin
                errs++;
                $display("FAIL conflict inst%0d: got %b want %b", k, o[k], e);
            end
        end
        CS_n = 1'b1;
        RD_n = 1'b1;
        WR_n = 1'b1;
        repeat (SD + 2) step();
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL err_sticky: got %b want %b", o[0], e);
        end
        A = 2'd2;
        CS_n = 1'b0;
        RD_n = 1'b0;
        repeat (SD + 2) step();
        e = {C_IDLE, 2'd2, 4'b1011};
        vecs++;
        if (o[2] !== e) begin
            errs++;
            $display("FAIL pre_reset_fetch: got %b want %b", o[2], e);
        end
        rst = 1'b0;
        CS_n = 1'b1;
        RD_n = 1'b1;
        step();
        e = {C_IDLE, 2'd0, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (o[k] !== e) begin
                errs++;
                $display("FAIL reset_mid_read inst%0d: got %b want %b", k, o[k], e);
            end
        end
        rst = 1'b1;
        A = 2'd3;
        CS_n = 1'b0;
        WR_n = 1'b0;
        repeat (SD + 1) step();
        e = {C_WL, 2'd3, 4'b0010};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL pre_reset_latch: got %b want %b", o[0], e);
        end
        rst = 1'b0;
        CS_n = 1'b1;
        WR_n = 1'b1;
        step();
        rst = 1'b1;
        e = {C_IDLE, 2'd0, 4'b0000};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL reset_mid_write: got %b want %b", o[0], e);
        end
        repeat (SD + 2) step();
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL after_reset_write: got %b want %b", o[0], e);
        end
        ps = 2'd0;
    endtask

    task automatic test_cs_inactive();
        logic [1:0] pat [6];
        logic [7:0] e;
        pat = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
        CS_n = 1'b1;
        e = {C_IDLE, ps, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            {RD_n, WR_n} = pat[i];
            A = 2'(i + 1);
            step();
            for (int k = 0; k < 3; k += 2) begin
                vecs++;
                if (o[k] !== e) begin
                    errs++;
                    $display("FAIL cs_inactive p%0d inst%0d: got %b want %b", i, k, o[k], e);
                end
            end
        end
        RD_n = 1'b1;
        WR_n = 1'b1;
        repeat (SD + 1) step();
        vecs++;
        if (o[1] !== e) begin
            errs++;
            $display("FAIL cs_inactive_tail: got %b want %b", o[1], e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        A = 2'd0;
        CS_n = 1'b0;
        WR_n = 1'b0;
        repeat (SD + 3) step();
        e = {C_IDLE, 2'd0, 4'b0010};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL b2b_wwait: got %b want %b", o[0], e);
        end
        WR_n = 1'b1;
        RD_n = 1'b0;
        A = 2'd1;
        repeat (SD) step();
        step();
        e = {C_IDLE, 2'd0, 4'b0000};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL b2b_idle_gap: got %b want %b", o[0], e);
        end
        step();
        e = {C_IDLE, 2'd1, 4'b1010};
        vecs++;
        if (o[0] !== e) begin
            errs++;
            $display("FAIL b2b_read_start: got %b want %b", o[0], e);
        end
        CS_n = 1'b1;
        RD_n = 1'b1;
        repeat (SD + 4) step();
        ps = 2'd1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_abort();
        test_short_write();
        test_conflict_reset();
        test_cs_inactive();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
